// File: rtl/dma_split_pkg.sv
// Shared types and helpers for the DMA burst splitter: FSM states, transfer
// direction, the latched request and the chunk-length clamp.
package dma_split_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CTRL = 3'd1,
    RD_DATA = 3'd2,
    WR_CTRL = 3'd3,
    WR_DATA = 3'd4
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } dir_e;

  typedef struct packed {
    logic [31:0] index;
    logic [8:0]  total;
    logic [2:0]  size;
  } req_t;

  function automatic logic [8:0] min_beats(input logic [8:0] remaining,
                                           input logic [8:0] max_beats);
    return (remaining < max_beats) ? remaining : max_beats;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter2.sv
// Two-way round-robin grant between read and write requests; last_grant only
// moves when a grant is actually issued, so a grant doubles as the handshake.
module dma_rr_arbiter2
  import dma_split_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_rd_i,
  input  logic req_wr_i,
  output logic gnt_rd_o,
  output logic gnt_wr_o
);

  dir_e last_q;

  assign gnt_rd_o = en_i && req_rd_i && (!req_wr_i || (last_q == WRITE));
  assign gnt_wr_o = en_i && req_wr_i && (!req_rd_i || (last_q == READ));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= WRITE;
    end else if (gnt_rd_o) begin
      last_q <= READ;
    end else if (gnt_wr_o) begin
      last_q <= WRITE;
    end
  end

endmodule

// File: rtl/dma_burst_splitter.sv
// Converts one AXI-style DMA request at a time into socket requests of at most
// MAX_BEATS beats, gating the data channels to the chunk currently in flight.
module dma_burst_splitter
  import dma_split_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_rd_ctrl_valid,
  output logic                  in_rd_ctrl_ready,
  input  logic [31:0]           in_rd_ctrl_index,
  input  logic [31:0]           in_rd_ctrl_length,
  input  logic [2:0]            in_rd_ctrl_size,
  input  logic                  in_wr_ctrl_valid,
  output logic                  in_wr_ctrl_ready,
  input  logic [31:0]           in_wr_ctrl_index,
  input  logic [31:0]           in_wr_ctrl_length,
  input  logic [2:0]            in_wr_ctrl_size,
  output logic                  out_rd_ctrl_valid,
  input  logic                  out_rd_ctrl_ready,
  output logic [31:0]           out_rd_ctrl_index,
  output logic [31:0]           out_rd_ctrl_length,
  output logic [2:0]            out_rd_ctrl_size,
  output logic                  out_wr_ctrl_valid,
  input  logic                  out_wr_ctrl_ready,
  output logic [31:0]           out_wr_ctrl_index,
  output logic [31:0]           out_wr_ctrl_length,
  output logic [2:0]            out_wr_ctrl_size,
  input  logic                  sock_rd_chnl_valid,
  input  logic [DATA_WIDTH-1:0] sock_rd_chnl_data,
  output logic                  sock_rd_chnl_ready,
  output logic                  up_rd_chnl_valid,
  output logic [DATA_WIDTH-1:0] up_rd_chnl_data,
  input  logic                  up_rd_chnl_ready,
  output logic                  up_rd_last,
  input  logic                  up_wr_chnl_valid,
  input  logic [DATA_WIDTH-1:0] up_wr_chnl_data,
  output logic                  up_wr_chnl_ready,
  output logic                  sock_wr_chnl_valid,
  output logic [DATA_WIDTH-1:0] sock_wr_chnl_data,
  input  logic                  sock_wr_chnl_ready,
  output logic                  up_wr_last,
  output logic                  busy
);

  localparam int         SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [8:0] MAXB  = 9'(MAX_BEATS);

  state_e      state_q;
  logic [31:0] idx_q;
  logic [8:0]  rem_q;
  logic [8:0]  chunk_q;
  logic [8:0]  len_q;
  logic [2:0]  size_q;

  logic        gnt_rd, gnt_wr;
  req_t        in_req;
  logic [8:0]  cur_len;
  logic        ctrl_hs, rd_beat, wr_beat;
  logic        unused_len;

  // Only AXI len[7:0] is meaningful; the upper bits are ignored.
  assign unused_len = ^{in_rd_ctrl_length[31:8], in_wr_ctrl_length[31:8]};

  dma_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == IDLE),
    .req_rd_i (in_rd_ctrl_valid),
    .req_wr_i (in_wr_ctrl_valid),
    .gnt_rd_o (gnt_rd),
    .gnt_wr_o (gnt_wr)
  );

  always_comb begin
    in_req = '0;
    if (gnt_rd) begin
      in_req.index = in_rd_ctrl_index >> SHIFT;
      in_req.total = {1'b0, in_rd_ctrl_length[7:0]} + 9'd1;
      in_req.size  = in_rd_ctrl_size;
    end else if (gnt_wr) begin
      in_req.index = in_wr_ctrl_index >> SHIFT;
      in_req.total = {1'b0, in_wr_ctrl_length[7:0]} + 9'd1;
      in_req.size  = in_wr_ctrl_size;
    end
  end

  assign cur_len = min_beats(rem_q, MAXB);
  assign ctrl_hs = ((state_q == RD_CTRL) && out_rd_ctrl_ready) ||
                   ((state_q == WR_CTRL) && out_wr_ctrl_ready);
  assign rd_beat = (state_q == RD_DATA) && sock_rd_chnl_valid && up_rd_chnl_ready;
  assign wr_beat = (state_q == WR_DATA) && up_wr_chnl_valid && sock_wr_chnl_ready;

  assign in_rd_ctrl_ready   = gnt_rd;
  assign in_wr_ctrl_ready   = gnt_wr;
  assign out_rd_ctrl_valid  = (state_q == RD_CTRL);
  assign out_rd_ctrl_index  = idx_q;
  assign out_rd_ctrl_length = {23'b0, cur_len};
  assign out_rd_ctrl_size   = size_q;
  assign out_wr_ctrl_valid  = (state_q == WR_CTRL);
  assign out_wr_ctrl_index  = idx_q;
  assign out_wr_ctrl_length = {23'b0, cur_len};
  assign out_wr_ctrl_size   = size_q;

  // Data channels are wired straight through only while their chunk is active.
  assign up_rd_chnl_valid   = (state_q == RD_DATA) && sock_rd_chnl_valid;
  assign sock_rd_chnl_ready = (state_q == RD_DATA) && up_rd_chnl_ready;
  assign up_rd_chnl_data    = sock_rd_chnl_data;
  assign up_rd_last         = (state_q == RD_DATA) && sock_rd_chnl_valid && (rem_q == 9'd1);
  assign sock_wr_chnl_valid = (state_q == WR_DATA) && up_wr_chnl_valid;
  assign up_wr_chnl_ready   = (state_q == WR_DATA) && sock_wr_chnl_ready;
  assign sock_wr_chnl_data  = up_wr_chnl_data;
  assign up_wr_last         = wr_beat && (rem_q == 9'd1);
  assign busy               = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_rd || gnt_wr) begin
            idx_q   <= in_req.index;
            rem_q   <= in_req.total;
            size_q  <= in_req.size;
            state_q <= gnt_rd ? RD_CTRL : WR_CTRL;
          end
        end
        RD_CTRL, WR_CTRL: begin
          if (ctrl_hs) begin
            chunk_q <= cur_len;
            len_q   <= cur_len;
            state_q <= (state_q == RD_CTRL) ? RD_DATA : WR_DATA;
          end
        end
        RD_DATA, WR_DATA: begin
          if (rd_beat || wr_beat) begin
            chunk_q <= chunk_q - 9'd1;
            rem_q   <= rem_q - 9'd1;
            if (chunk_q == 9'd1) begin
              // Next chunk starts where this one ended; the index wraps mod 2^32.
              if (rem_q != 9'd1) begin
                idx_q   <= idx_q + {23'b0, len_q};
                state_q <= (state_q == RD_DATA) ? RD_CTRL : WR_CTRL;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Randomized bench for dma_burst_splitter: every request is expanded into its
// expected chunk list and beat sequence by a simple arithmetic model.
module tb_dma_burst_splitter;

  localparam int DW   = 64;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_rd_ctrl_valid = 1'b0, in_wr_ctrl_valid = 1'b0;
  logic          in_rd_ctrl_ready, in_wr_ctrl_ready;
  logic [31:0]   in_rd_ctrl_index = '0, in_rd_ctrl_length = '0;
  logic [31:0]   in_wr_ctrl_index = '0, in_wr_ctrl_length = '0;
  logic [2:0]    in_rd_ctrl_size = '0, in_wr_ctrl_size = '0;
  logic          out_rd_ctrl_valid, out_wr_ctrl_valid;
  logic          out_rd_ctrl_ready = 1'b0, out_wr_ctrl_ready = 1'b0;
  logic [31:0]   out_rd_ctrl_index, out_rd_ctrl_length;
  logic [31:0]   out_wr_ctrl_index, out_wr_ctrl_length;
  logic [2:0]    out_rd_ctrl_size, out_wr_ctrl_size;
  logic          sock_rd_chnl_valid = 1'b0, sock_rd_chnl_ready;
  logic [DW-1:0] sock_rd_chnl_data = '0;
  logic          up_rd_chnl_valid, up_rd_chnl_ready = 1'b0, up_rd_last;
  logic [DW-1:0] up_rd_chnl_data;
  logic          up_wr_chnl_valid = 1'b0, up_wr_chnl_ready;
  logic [DW-1:0] up_wr_chnl_data = '0;
  logic          sock_wr_chnl_valid, sock_wr_chnl_ready = 1'b0, up_wr_last;
  logic [DW-1:0] sock_wr_chnl_data;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit model_last;  // 0 = read granted last, 1 = write granted last

  dma_burst_splitter #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .in_rd_ctrl_valid(in_rd_ctrl_valid), .in_rd_ctrl_ready(in_rd_ctrl_ready),
    .in_rd_ctrl_index(in_rd_ctrl_index), .in_rd_ctrl_length(in_rd_ctrl_length),
    .in_rd_ctrl_size(in_rd_ctrl_size),
    .in_wr_ctrl_valid(in_wr_ctrl_valid), .in_wr_ctrl_ready(in_wr_ctrl_ready),
    .in_wr_ctrl_index(in_wr_ctrl_index), .in_wr_ctrl_length(in_wr_ctrl_length),
    .in_wr_ctrl_size(in_wr_ctrl_size),
    .out_rd_ctrl_valid(out_rd_ctrl_valid), .out_rd_ctrl_ready(out_rd_ctrl_ready),
    .out_rd_ctrl_index(out_rd_ctrl_index), .out_rd_ctrl_length(out_rd_ctrl_length),
    .out_rd_ctrl_size(out_rd_ctrl_size),
    .out_wr_ctrl_valid(out_wr_ctrl_valid), .out_wr_ctrl_ready(out_wr_ctrl_ready),
    .out_wr_ctrl_index(out_wr_ctrl_index), .out_wr_ctrl_length(out_wr_ctrl_length),
    .out_wr_ctrl_size(out_wr_ctrl_size),
    .sock_rd_chnl_valid(sock_rd_chnl_valid), .sock_rd_chnl_data(sock_rd_chnl_data),
    .sock_rd_chnl_ready(sock_rd_chnl_ready),
    .up_rd_chnl_valid(up_rd_chnl_valid), .up_rd_chnl_data(up_rd_chnl_data),
    .up_rd_chnl_ready(up_rd_chnl_ready), .up_rd_last(up_rd_last),
    .up_wr_chnl_valid(up_wr_chnl_valid), .up_wr_chnl_data(up_wr_chnl_data),
    .up_wr_chnl_ready(up_wr_chnl_ready),
    .sock_wr_chnl_valid(sock_wr_chnl_valid), .sock_wr_chnl_data(sock_wr_chnl_data),
    .sock_wr_chnl_ready(sock_wr_chnl_ready), .up_wr_last(up_wr_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [10:0] all_outs();
    return {out_rd_ctrl_valid, out_wr_ctrl_valid, in_rd_ctrl_ready, in_wr_ctrl_ready,
            up_rd_chnl_valid, sock_rd_chnl_ready, up_wr_chnl_ready, sock_wr_chnl_valid,
            up_rd_last, up_wr_last, busy};
  endfunction

  task automatic clear_chnl();
    sock_rd_chnl_valid = 1'b0; up_rd_chnl_ready = 1'b0;
    up_wr_chnl_valid = 1'b0;   sock_wr_chnl_ready = 1'b0;
    out_rd_ctrl_ready = 1'b0;  out_wr_ctrl_ready = 1'b0;
  endtask

  // Runs one request (d: 0 read, 1 write) end to end starting at a falling edge.
  // abort_at >= 0 pulls reset while that zero-based beat is being offered.
  task automatic serve(input bit d, input logic [31:0] addr, input logic [7:0] len,
                       input int abort_at);
    logic [31:0] idx;
    logic [2:0]  sz;
    logic [63:0] dv;
    int total, rem, clen, beat, n;
    bit ok, v, r;
    total = int'(len) + 1;
    rem   = total;
    beat  = 0;
    idx   = addr >> 3;
    sz    = 3'($urandom_range(0, 7));
    if (!d) begin
      in_rd_ctrl_index = addr; in_rd_ctrl_length = {$urandom_range(0, 255) > 128 ? 24'hABCDEF : 24'h0, len};
      in_rd_ctrl_size = sz; in_rd_ctrl_valid = 1'b1;
    end else begin
      in_wr_ctrl_index = addr; in_wr_ctrl_length = {$urandom_range(0, 255) > 128 ? 24'h123456 : 24'h0, len};
      in_wr_ctrl_size = sz; in_wr_ctrl_valid = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (d ? in_wr_ctrl_ready : in_rd_ctrl_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("req_grant", 64'(ok), 64'd1);
    chk("req_other_rdy", 64'(d ? in_rd_ctrl_ready : in_wr_ctrl_ready), 64'd0);
    @(negedge clk);
    if (!d) in_rd_ctrl_valid = 1'b0; else in_wr_ctrl_valid = 1'b0;
    if (!ok) return;
    model_last = d;
    while (rem > 0) begin
      clen = (rem < MAXB) ? rem : MAXB;
      if (!d) sock_rd_chnl_valid = 1'($urandom_range(0, 1));
      else    up_wr_chnl_valid   = 1'($urandom_range(0, 1));
      up_rd_chnl_ready = 1'b1; sock_wr_chnl_ready = 1'b1;
      #1;
      chk("ctrl_valid", 64'(d ? out_wr_ctrl_valid : out_rd_ctrl_valid), 64'd1);
      chk("ctrl_index", 64'(d ? out_wr_ctrl_index : out_rd_ctrl_index), 64'(idx));
      chk("ctrl_len", 64'(d ? out_wr_ctrl_length : out_rd_ctrl_length), 64'(clen));
      chk("ctrl_size", 64'(d ? out_wr_ctrl_size : out_rd_ctrl_size), 64'(sz));
      chk("ctrl_gate", 64'({sock_rd_chnl_ready, up_rd_chnl_valid, up_wr_chnl_ready,
                            sock_wr_chnl_valid, up_rd_last, up_wr_last}), 64'd0);
      chk("ctrl_rdy_busy", 64'({in_rd_ctrl_ready, in_wr_ctrl_ready}), 64'd0);
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
        r = 1'($urandom_range(0, 1));
        if (!d) out_rd_ctrl_ready = r; else out_wr_ctrl_ready = r;
        @(negedge clk);
        out_rd_ctrl_ready = 1'b0; out_wr_ctrl_ready = 1'b0;
        if (r) begin ok = 1'b1; break; end
        #1;
        chk("ctrl_hold", 64'({d ? out_wr_ctrl_valid : out_rd_ctrl_valid,
                              d ? out_wr_ctrl_index : out_rd_ctrl_index}), 64'({1'b1, idx}));
      end
      chk("ctrl_hs", 64'(ok), 64'd1);
      if (!ok) begin clear_chnl(); return; end
      n = 0;
      for (int cyc = 0; cyc < 400 && n < clen; cyc++) begin
        if (beat == abort_at) begin
          sock_rd_chnl_valid = 1'b1; up_rd_chnl_ready = 1'b1;
          #1;
          rst = 1'b0;
          #1;
          chk("abort_outs", 64'(all_outs()), 64'd0);
          clear_chnl();
          return;
        end
        v  = 1'($urandom_range(0, 1));
        r  = 1'($urandom_range(0, 1));
        dv = {$urandom(), $urandom()};
        if (!d) begin
          sock_rd_chnl_valid = v; sock_rd_chnl_data = dv; up_rd_chnl_ready = r;
        end else begin
          up_wr_chnl_valid = v; up_wr_chnl_data = dv; sock_wr_chnl_ready = r;
        end
        #1;
        if (!d) begin
          chk("rd_valid", 64'(up_rd_chnl_valid), 64'(v));
          chk("rd_ready", 64'(sock_rd_chnl_ready), 64'(r));
          if (v) chk("rd_data", up_rd_chnl_data, dv);
          chk("rd_last", 64'(up_rd_last), 64'(v && (beat == total - 1)));
        end else begin
          chk("wr_valid", 64'(sock_wr_chnl_valid), 64'(v));
          chk("wr_ready", 64'(up_wr_chnl_ready), 64'(r));
          if (v) chk("wr_data", sock_wr_chnl_data, dv);
          chk("wr_last", 64'(up_wr_last), 64'(v && r && (beat == total - 1)));
        end
        chk("data_rdy_busy", 64'({in_rd_ctrl_ready, in_wr_ctrl_ready, out_rd_ctrl_valid,
                                  out_wr_ctrl_valid}), 64'd0);
        if (v && r) begin n++; beat++; rem--; end
        @(negedge clk);
      end
      chk("chunk_beats", 64'(n), 64'(clen));
      if (n != clen) begin clear_chnl(); return; end
      idx = idx + 32'(clen);
    end
    clear_chnl();
    #1;
    chk("done_idle", 64'({busy, up_rd_chnl_valid, sock_wr_chnl_valid}), 64'd0);
  endtask

  // Both directions request together; the model picks the round-robin winner.
  task automatic pair(input logic [31:0] ra, input logic [7:0] rl,
                      input logic [31:0] wa, input logic [7:0] wl);
    bit win;
    win = (model_last == 1'b1) ? 1'b0 : 1'b1;
    in_rd_ctrl_index = ra; in_rd_ctrl_length = {24'h0, rl}; in_rd_ctrl_valid = 1'b1;
    in_wr_ctrl_index = wa; in_wr_ctrl_length = {24'h0, wl}; in_wr_ctrl_valid = 1'b1;
    if (!win) begin
      serve(1'b0, ra, rl, -1);
      serve(1'b1, wa, wl, -1);
    end else begin
      serve(1'b1, wa, wl, -1);
      serve(1'b0, ra, rl, -1);
    end
  endtask

  initial begin
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 64'(all_outs()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);
    @(negedge clk);

    serve(1'b0, 32'h0000_0100, 8'd3, -1);
    serve(1'b1, 32'h0000_0000, 8'd39, -1);
    pair(32'h0000_1000, 8'd5, 32'h0000_2000, 8'd17);
    pair(32'h0000_3000, 8'd0, 32'h0000_4000, 8'd2);
    serve(1'b0, 32'hFFFF_FFF8, 8'd0, -1);
    serve(1'b1, 32'hFFFF_FF80, 8'd16, -1);
    serve(1'b0, 32'h0000_0040, 8'd15, -1);

    for (int i = 0; i < 8; i++) begin
      serve(1'($urandom_range(0, 1)), $urandom(), 8'($urandom_range(0, 70)), -1);
    end

    serve(1'b0, 32'h0000_8000, 8'd19, 4);
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    serve(1'b0, 32'h0000_0200, 8'd1, -1);
    pair(32'h0000_0300, 8'd2, 32'h0000_0400, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
